// File: rtl/rs_wakeup_table.sv
// Reservation-station wakeup/select table: sticky per-source ready bits, CDB snoop with allocate bypass.
// Wakeup-to-ready and alloc-to-issue latency 1 cycle; select is combinational from state; no backpressure beyond issue_ack.
module rs_wakeup_table #(
  parameter int NUM_ENTRIES = 8,
  parameter int NUM_CDB     = 2,
  parameter int TAG_W       = 6,
  parameter int IDX_W       = 3
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     flush,
  input  logic                     alloc_valid,
  input  logic [IDX_W-1:0]         alloc_idx,
  input  logic [TAG_W-1:0]         alloc_src1_tag,
  input  logic                     alloc_src1_ready,
  input  logic [TAG_W-1:0]         alloc_src2_tag,
  input  logic                     alloc_src2_ready,
  input  logic [NUM_CDB-1:0]       cdb_valid,
  input  logic [NUM_CDB*TAG_W-1:0] cdb_tag,
  input  logic                     issue_ack,
  output logic [NUM_ENTRIES-1:0]   entry_valid,
  output logic [NUM_ENTRIES-1:0]   entry_ready,
  output logic                     issue_valid,
  output logic [IDX_W-1:0]         issue_idx,
  output logic [TAG_W-1:0]         issue_src1_tag,
  output logic [TAG_W-1:0]         issue_src2_tag,
  output logic                     alloc_conflict
);

  logic [NUM_ENTRIES-1:0] r_valid;
  logic [NUM_ENTRIES-1:0] r_s1_rdy;
  logic [NUM_ENTRIES-1:0] r_s2_rdy;
  logic [TAG_W-1:0]       r_s1_tag [NUM_ENTRIES];
  logic [TAG_W-1:0]       r_s2_tag [NUM_ENTRIES];
  logic                   r_conflict;

  logic [NUM_ENTRIES-1:0] w_s1_hit;
  logic [NUM_ENTRIES-1:0] w_s2_hit;
  logic [NUM_ENTRIES-1:0] w_free;
  logic [NUM_ENTRIES-1:0] w_write;
  logic                   w_a1_hit;
  logic                   w_a2_hit;
  logic                   w_any;
  logic                   w_fire;
  logic                   w_alloc_ok;
  logic [IDX_W-1:0]       w_idx;

  always_comb begin
    w_s1_hit = '0;
    w_s2_hit = '0;
    w_a1_hit = 1'b0;
    w_a2_hit = 1'b0;
    for (int k = 0; k < NUM_CDB; k++) begin
      if (cdb_valid[k]) begin
        for (int i = 0; i < NUM_ENTRIES; i++) begin
          if (cdb_tag[k*TAG_W +: TAG_W] == r_s1_tag[i]) w_s1_hit[i] = 1'b1;
          if (cdb_tag[k*TAG_W +: TAG_W] == r_s2_tag[i]) w_s2_hit[i] = 1'b1;
        end
        if (cdb_tag[k*TAG_W +: TAG_W] == alloc_src1_tag) w_a1_hit = 1'b1;
        if (cdb_tag[k*TAG_W +: TAG_W] == alloc_src2_tag) w_a2_hit = 1'b1;
      end
    end
  end

  assign entry_valid = r_valid;
  assign entry_ready = r_valid & r_s1_rdy & r_s2_rdy;

  // Descending scan so the lowest ready index is the last one written.
  always_comb begin
    w_idx = '0;
    w_any = 1'b0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (entry_ready[i]) begin
        w_idx = IDX_W'(i);
        w_any = 1'b1;
      end
    end
  end

  assign issue_valid    = w_any;
  assign issue_idx      = w_idx;
  assign issue_src1_tag = w_any ? r_s1_tag[w_idx] : '0;
  assign issue_src2_tag = w_any ? r_s2_tag[w_idx] : '0;
  assign alloc_conflict = r_conflict;
  assign w_fire         = issue_ack & w_any;

  // An entry being issued this cycle counts as free for a same-cycle allocate.
  always_comb begin
    w_free = '0;
    if (w_fire) w_free[w_idx] = 1'b1;
    w_alloc_ok = alloc_valid & (~r_valid[alloc_idx] | w_free[alloc_idx]);
    w_write = '0;
    if (w_alloc_ok) w_write[alloc_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid    <= '0;
      r_s1_rdy   <= '0;
      r_s2_rdy   <= '0;
      r_conflict <= 1'b0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        r_s1_tag[i] <= '0;
        r_s2_tag[i] <= '0;
      end
    end else if (flush) begin
      r_valid    <= '0;
      r_s1_rdy   <= '0;
      r_s2_rdy   <= '0;
      r_conflict <= 1'b0;
    end else begin
      r_conflict <= alloc_valid & ~w_alloc_ok;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        if (w_write[i]) begin
          r_valid[i]  <= 1'b1;
          r_s1_tag[i] <= alloc_src1_tag;
          r_s2_tag[i] <= alloc_src2_tag;
          r_s1_rdy[i] <= alloc_src1_ready | w_a1_hit;
          r_s2_rdy[i] <= alloc_src2_ready | w_a2_hit;
        end else if (w_free[i]) begin
          r_valid[i] <= 1'b0;
        end else if (r_valid[i]) begin
          r_s1_rdy[i] <= r_s1_rdy[i] | w_s1_hit[i];
          r_s2_rdy[i] <= r_s2_rdy[i] | w_s2_hit[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_rs_wakeup_table.sv
// Bench for rs_wakeup_table: directed scenarios plus randomized traffic against an entry-level table model.
module tb_rs_wakeup_table;
  localparam int N  = 8;
  localparam int C  = 2;
  localparam int TW = 6;
  localparam int IW = 3;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          flush;
  logic          alloc_valid;
  logic [IW-1:0] alloc_idx;
  logic [TW-1:0] alloc_src1_tag;
  logic          alloc_src1_ready;
  logic [TW-1:0] alloc_src2_tag;
  logic          alloc_src2_ready;
  logic [C-1:0]  cdb_valid;
  logic [C*TW-1:0] cdb_tag;
  logic          issue_ack;
  logic [N-1:0]  entry_valid;
  logic [N-1:0]  entry_ready;
  logic          issue_valid;
  logic [IW-1:0] issue_idx;
  logic [TW-1:0] issue_src1_tag;
  logic [TW-1:0] issue_src2_tag;
  logic          alloc_conflict;

  int errors = 0;
  int checks = 0;

  bit            m_valid [N];
  bit            m_r1    [N];
  bit            m_r2    [N];
  logic [TW-1:0] m_t1    [N];
  logic [TW-1:0] m_t2    [N];
  bit            m_conf;

  rs_wakeup_table #(.NUM_ENTRIES(N), .NUM_CDB(C), .TAG_W(TW), .IDX_W(IW)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .alloc_valid(alloc_valid), .alloc_idx(alloc_idx),
    .alloc_src1_tag(alloc_src1_tag), .alloc_src1_ready(alloc_src1_ready),
    .alloc_src2_tag(alloc_src2_tag), .alloc_src2_ready(alloc_src2_ready),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .issue_ack(issue_ack),
    .entry_valid(entry_valid), .entry_ready(entry_ready),
    .issue_valid(issue_valid), .issue_idx(issue_idx),
    .issue_src1_tag(issue_src1_tag), .issue_src2_tag(issue_src2_tag),
    .alloc_conflict(alloc_conflict)
  );

  always #5 clk = ~clk;

  function automatic bit bcast(input logic [TW-1:0] t);
    for (int k = 0; k < C; k++)
      if (cdb_valid[k] && cdb_tag[k*TW +: TW] == t) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int m_sel();
    for (int i = 0; i < N; i++)
      if (m_valid[i] && m_r1[i] && m_r2[i]) return i;
    return -1;
  endfunction

  function automatic logic [N-1:0] m_vld_vec();
    logic [N-1:0] v = '0;
    for (int i = 0; i < N; i++) v[i] = m_valid[i];
    return v;
  endfunction

  function automatic logic [N-1:0] m_rdy_vec();
    logic [N-1:0] v = '0;
    for (int i = 0; i < N; i++) v[i] = m_valid[i] && m_r1[i] && m_r2[i];
    return v;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      m_valid[i] = 0; m_r1[i] = 0; m_r2[i] = 0; m_t1[i] = '0; m_t2[i] = '0;
    end
    m_conf = 0;
  endtask

  task automatic model_step();
    int  s;
    bit  fire;
    bit  blocked;
    s = m_sel();
    fire = issue_ack && (s >= 0);
    if (flush) begin
      for (int i = 0; i < N; i++) m_valid[i] = 0;
      m_conf = 0;
      return;
    end
    blocked = alloc_valid && m_valid[alloc_idx] && !(fire && s == int'(alloc_idx));
    for (int i = 0; i < N; i++) begin
      if (m_valid[i] && bcast(m_t1[i])) m_r1[i] = 1;
      if (m_valid[i] && bcast(m_t2[i])) m_r2[i] = 1;
    end
    if (fire) m_valid[s] = 0;
    if (alloc_valid && !blocked) begin
      m_valid[alloc_idx] = 1;
      m_t1[alloc_idx] = alloc_src1_tag;
      m_t2[alloc_idx] = alloc_src2_tag;
      m_r1[alloc_idx] = alloc_src1_ready || bcast(alloc_src1_tag);
      m_r2[alloc_idx] = alloc_src2_ready || bcast(alloc_src2_tag);
    end
    m_conf = blocked;
  endtask

  task automatic idle();
    flush = 0; alloc_valid = 0; alloc_idx = '0;
    alloc_src1_tag = '0; alloc_src1_ready = 0; alloc_src2_tag = '0; alloc_src2_ready = 0;
    cdb_valid = '0; cdb_tag = '0; issue_ack = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    idle();
  endtask

  task automatic alloc(input int idx, input int t1, input bit r1, input int t2, input bit r2);
    alloc_valid = 1; alloc_idx = IW'(idx);
    alloc_src1_tag = TW'(t1); alloc_src1_ready = r1;
    alloc_src2_tag = TW'(t2); alloc_src2_ready = r2;
  endtask

  task automatic do_flush();
    flush = 1;
    tick();
  endtask

  task automatic test_reset();
    reset_n = 0;
    idle();
    repeat (2) @(negedge clk);
    model_clear();
    checks++; if (entry_valid !== '0) begin errors++; $display("FAIL reset_entry_valid: got %h want 0", entry_valid); end
    checks++; if (entry_ready !== '0) begin errors++; $display("FAIL reset_entry_ready: got %h want 0", entry_ready); end
    checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL reset_issue_valid: got %b want 0", issue_valid); end
    checks++; if (issue_idx !== '0 || issue_src1_tag !== '0 || issue_src2_tag !== '0) begin
      errors++; $display("FAIL reset_issue_fields: idx=%0d t1=%0d t2=%0d want 0", issue_idx, issue_src1_tag, issue_src2_tag);
    end
    checks++; if (alloc_conflict !== 1'b0) begin errors++; $display("FAIL reset_conflict: got %b want 0", alloc_conflict); end
    reset_n = 1;
  endtask

  task automatic test_wakeup();
    alloc(2, 5, 0, 9, 1);
    tick();
    checks++; if (entry_valid !== 8'h04 || entry_ready !== 8'h00) begin
      errors++; $display("FAIL wakeup_pending: valid=%h ready=%h want 04/00", entry_valid, entry_ready);
    end
    cdb_valid = 2'b01; cdb_tag = {6'd0, 6'd5};
    tick();
    checks++; if (entry_ready !== 8'h04) begin errors++; $display("FAIL wakeup_ready: got %h want 04", entry_ready); end
    checks++; if (issue_valid !== 1'b1 || issue_idx !== 3'd2) begin
      errors++; $display("FAIL wakeup_issue: valid=%b idx=%0d want 1/2", issue_valid, issue_idx);
    end
    checks++; if (issue_src1_tag !== 6'd5 || issue_src2_tag !== 6'd9) begin
      errors++; $display("FAIL wakeup_tags: t1=%0d t2=%0d want 5/9", issue_src1_tag, issue_src2_tag);
    end
    do_flush();
  endtask

  task automatic test_bypass();
    alloc(1, 12, 0, 13, 0);
    cdb_valid = 2'b11; cdb_tag = {6'd13, 6'd12};
    tick();
    checks++; if (entry_ready !== 8'h02) begin errors++; $display("FAIL bypass_ready: got %h want 02", entry_ready); end
    checks++; if (issue_src1_tag !== 6'd12 || issue_src2_tag !== 6'd13) begin
      errors++; $display("FAIL bypass_tags: t1=%0d t2=%0d want 12/13", issue_src1_tag, issue_src2_tag);
    end
    do_flush();
  endtask

  task automatic test_select_order();
    alloc(6, 30, 1, 31, 1);
    tick();
    alloc(3, 40, 1, 41, 1);
    tick();
    checks++; if (issue_idx !== 3'd3 || issue_src1_tag !== 6'd40) begin
      errors++; $display("FAIL select_lowest: idx=%0d t1=%0d want 3/40", issue_idx, issue_src1_tag);
    end
    issue_ack = 1;
    tick();
    checks++; if (entry_valid[3] !== 1'b0) begin errors++; $display("FAIL select_acked_cleared: got %b want 0", entry_valid[3]); end
    checks++; if (issue_idx !== 3'd6 || issue_src2_tag !== 6'd31) begin
      errors++; $display("FAIL select_next: idx=%0d t2=%0d want 6/31", issue_idx, issue_src2_tag);
    end
    do_flush();
  endtask

  task automatic test_conflict();
    alloc(4, 1, 0, 2, 0);
    tick();
    alloc(4, 7, 1, 8, 1);
    tick();
    checks++; if (alloc_conflict !== 1'b1) begin errors++; $display("FAIL conflict_pulse: got %b want 1", alloc_conflict); end
    checks++; if (entry_valid !== 8'h10 || entry_ready !== 8'h00) begin
      errors++; $display("FAIL conflict_unchanged: valid=%h ready=%h want 10/00", entry_valid, entry_ready);
    end
    tick();
    checks++; if (alloc_conflict !== 1'b0) begin errors++; $display("FAIL conflict_one_cycle: got %b want 0", alloc_conflict); end
    cdb_valid = 2'b11; cdb_tag = {6'd2, 6'd1};
    tick();
    checks++; if (issue_idx !== 3'd4 || issue_src1_tag !== 6'd1 || issue_src2_tag !== 6'd2) begin
      errors++; $display("FAIL conflict_tags_kept: idx=%0d t1=%0d t2=%0d want 4/1/2", issue_idx, issue_src1_tag, issue_src2_tag);
    end
    do_flush();
  endtask

  task automatic test_back_to_back();
    alloc(0, 3, 1, 4, 1);
    tick();
    issue_ack = 1;
    alloc(0, 20, 0, 21, 0);
    cdb_valid = 2'b10; cdb_tag = {6'd20, 6'd0};
    tick();
    checks++; if (alloc_conflict !== 1'b0) begin errors++; $display("FAIL b2b_conflict: got %b want 0", alloc_conflict); end
    checks++; if (entry_valid !== 8'h01 || entry_ready !== 8'h00) begin
      errors++; $display("FAIL b2b_realloc: valid=%h ready=%h want 01/00", entry_valid, entry_ready);
    end
    cdb_valid = 2'b01; cdb_tag = {6'd0, 6'd21};
    tick();
    checks++; if (issue_valid !== 1'b1 || issue_src1_tag !== 6'd20 || issue_src2_tag !== 6'd21) begin
      errors++; $display("FAIL b2b_new_tags: v=%b t1=%0d t2=%0d want 1/20/21", issue_valid, issue_src1_tag, issue_src2_tag);
    end
    do_flush();
  endtask

  task automatic test_flush();
    for (int i = 0; i < N; i++) begin
      alloc(i, i + 1, 1, i + 2, 1);
      tick();
    end
    checks++; if (entry_valid !== 8'hFF || issue_valid !== 1'b1) begin
      errors++; $display("FAIL flush_filled: valid=%h iv=%b want ff/1", entry_valid, issue_valid);
    end
    flush = 1; issue_ack = 1;
    alloc(0, 50, 1, 51, 1);
    tick();
    checks++; if (entry_valid !== 8'h00) begin errors++; $display("FAIL flush_valid: got %h want 00", entry_valid); end
    checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL flush_issue_valid: got %b want 0", issue_valid); end
    checks++; if (alloc_conflict !== 1'b0) begin errors++; $display("FAIL flush_conflict: got %b want 0", alloc_conflict); end
  endtask

  task automatic test_async_reset();
    alloc(1, 10, 1, 11, 1);
    tick();
    alloc(5, 12, 1, 13, 1);
    tick();
    alloc(1, 14, 1, 15, 1);
    tick();
    checks++; if (alloc_conflict !== 1'b1 || issue_valid !== 1'b1) begin
      errors++; $display("FAIL areset_setup: conflict=%b iv=%b want 1/1", alloc_conflict, issue_valid);
    end
    #2 reset_n = 0;
    #1;
    model_clear();
    checks++; if (entry_valid !== 8'h00) begin errors++; $display("FAIL areset_valid: got %h want 00", entry_valid); end
    checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL areset_issue_valid: got %b want 0", issue_valid); end
    checks++; if (alloc_conflict !== 1'b0) begin errors++; $display("FAIL areset_conflict: got %b want 0", alloc_conflict); end
    @(negedge clk);
    reset_n = 1;
    alloc(1, 16, 1, 17, 1);
    tick();
    checks++; if (alloc_conflict !== 1'b0 || entry_valid !== 8'h02 || issue_src1_tag !== 6'd16) begin
      errors++; $display("FAIL areset_after: conflict=%b valid=%h t1=%0d want 0/02/16", alloc_conflict, entry_valid, issue_src1_tag);
    end
  endtask

  task automatic test_random();
    int s;
    for (int cyc = 0; cyc < 400; cyc++) begin
      flush = ($urandom_range(0, 99) < 2);
      if ($urandom_range(0, 99) < 60)
        alloc($urandom_range(0, N - 1), $urandom_range(0, 11), ($urandom_range(0, 3) == 0),
              $urandom_range(0, 11), ($urandom_range(0, 3) == 0));
      cdb_valid = C'($urandom_range(0, 3));
      cdb_tag = {TW'($urandom_range(0, 11)), TW'($urandom_range(0, 11))};
      issue_ack = ($urandom_range(0, 1) == 1);
      tick();
      s = m_sel();
      checks++; if (entry_valid !== m_vld_vec()) begin
        errors++; $display("FAIL rand_entry_valid cyc %0d: got %h want %h", cyc, entry_valid, m_vld_vec());
      end
      checks++; if (entry_ready !== m_rdy_vec()) begin
        errors++; $display("FAIL rand_entry_ready cyc %0d: got %h want %h", cyc, entry_ready, m_rdy_vec());
      end
      checks++; if (issue_valid !== (s >= 0)) begin
        errors++; $display("FAIL rand_issue_valid cyc %0d: got %b want %b", cyc, issue_valid, (s >= 0));
      end
      checks++; if (issue_idx !== ((s >= 0) ? IW'(s) : '0)) begin
        errors++; $display("FAIL rand_issue_idx cyc %0d: got %0d want %0d", cyc, issue_idx, (s >= 0) ? s : 0);
      end
      checks++; if (issue_src1_tag !== ((s >= 0) ? m_t1[s] : '0) || issue_src2_tag !== ((s >= 0) ? m_t2[s] : '0)) begin
        errors++; $display("FAIL rand_issue_tags cyc %0d: got %0d/%0d want %0d/%0d", cyc, issue_src1_tag, issue_src2_tag,
                           (s >= 0) ? m_t1[s] : '0, (s >= 0) ? m_t2[s] : '0);
      end
      checks++; if (alloc_conflict !== m_conf) begin
        errors++; $display("FAIL rand_conflict cyc %0d: got %b want %b", cyc, alloc_conflict, m_conf);
      end
    end
  endtask

  initial begin
    idle();
    test_reset();
    test_wakeup();
    test_bypass();
    test_select_order();
    test_conflict();
    test_back_to_back();
    test_flush();
    test_async_reset();
    do_flush();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
